// File: rtl/regfile_pkg.sv
// Shared widths and requester encoding for the register-file writeback arbiter.
// Optional feature macro used by the top: WB_BYPASS_EN.
package regfile_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 8;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } requester_e;

  // Round-robin hand-off: the pointer always moves to the requester that lost.
  function automatic requester_e other_req(input requester_e r);
    return (r == REQ_ALU) ? REQ_MEM : REQ_ALU;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin decision: one-hot grant, bit 0 = ALU, bit 1 = MEM.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic [1:0]  req,
  input  requester_e  ptr,
  output logic [1:0]  grant,
  output logic        contested
);

  // Uncontested requests win outright; the pointer only breaks ties.
  always_comb begin
    grant     = 2'b00;
    contested = req[0] & req[1];
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ptr == REQ_ALU) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load-unit writebacks onto one register-file write port and
// tracks pending destinations. Optional macro WB_BYPASS_EN adds read bypass ports.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_wreg,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_reg,
  output logic [NUM_REGS-1:0]   busy
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] rd_reg1,
  input  logic [REG_ADDR_W-1:0] rd_reg2,
  input  logic [DATA_W-1:0]     rf_r1,
  input  logic [DATA_W-1:0]     rf_r2,
  output logic [DATA_W-1:0]     rd_data1,
  output logic [DATA_W-1:0]     rd_data2
`endif
);

  requester_e             ptr_r;
  requester_e             ptr_nxt_s;
  logic [1:0]             grant_s;
  logic                   contested_s;
  logic                   alu_xfer_s;
  logic                   mem_xfer_s;
  logic [NUM_REGS-1:0]    busy_r;
  logic [NUM_REGS-1:0]    busy_nxt_s;
  logic                   rf_we_r;
  logic [REG_ADDR_W-1:0]  rf_wreg_r;
  logic [DATA_W-1:0]      rf_wdata_r;

  rr_arbiter2 u_arb (
    .req       ({mem_valid, alu_valid}),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .contested (contested_s)
  );

  // Ready is masked during reset so nothing can be accepted and then lost.
  assign alu_ready  = grant_s[0] & ~rst;
  assign mem_ready  = grant_s[1] & ~rst;
  assign alu_xfer_s = alu_valid & alu_ready;
  assign mem_xfer_s = mem_valid & mem_ready;

  // Pointer moves only when both requesters competed.
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (contested_s) begin
      ptr_nxt_s = grant_s[0] ? other_req(REQ_ALU) : other_req(REQ_MEM);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Scoreboard update: clear on writeback, then set on issue so set wins.
  always_comb begin
    busy_nxt_s = busy_r;
    if (alu_xfer_s) begin
      busy_nxt_s[alu_reg] = 1'b0;
    end else if (mem_xfer_s) begin
      busy_nxt_s[mem_reg] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (issue_valid) begin
      busy_nxt_s[issue_reg] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
  end

  // State and registered write port; rf_wreg/rf_wdata hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r      <= REQ_ALU;
      busy_r     <= 8'h00;
      rf_we_r    <= 1'b0;
      rf_wreg_r  <= 3'd0;
      rf_wdata_r <= 16'h0000;
    end else begin
      ptr_r  <= ptr_nxt_s;
      busy_r <= busy_nxt_s;
      if (alu_xfer_s) begin
        rf_we_r    <= 1'b1;
        rf_wreg_r  <= alu_reg;
        rf_wdata_r <= alu_data;
      end else if (mem_xfer_s) begin
        rf_we_r    <= 1'b1;
        rf_wreg_r  <= mem_reg;
        rf_wdata_r <= mem_data;
      end else begin
        rf_we_r    <= 1'b0;
      end
    end
  end

  assign rf_we    = rf_we_r;
  assign rf_wreg  = rf_wreg_r;
  assign rf_wdata = rf_wdata_r;
  assign busy     = busy_r;

`ifdef WB_BYPASS_EN
  assign rd_data1 = (rf_we_r && (rd_reg1 == rf_wreg_r)) ? rf_wdata_r : rf_r1;
  assign rd_data2 = (rf_we_r && (rd_reg2 == rf_wreg_r)) ? rf_wdata_r : rf_r2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed vectors plus a behavioural model checked every cycle.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0, issue_valid = 1'b0;
  logic [2:0]  alu_reg = 3'd0, mem_reg = 3'd0, issue_reg = 3'd0;
  logic [15:0] alu_data = 16'h0, mem_data = 16'h0;
  logic        alu_ready, mem_ready, rf_we;
  logic [2:0]  rf_wreg;
  logic [15:0] rf_wdata;
  logic [7:0]  busy;
`ifdef WB_BYPASS_EN
  logic [2:0]  rd_reg1 = 3'd0, rd_reg2 = 3'd0;
  logic [15:0] rf_r1 = 16'h0, rf_r2 = 16'h0;
  logic [15:0] rd_data1, rd_data2;
`endif

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .busy(busy)
`ifdef WB_BYPASS_EN
    , .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .rf_r1(rf_r1), .rf_r2(rf_r2),
    .rd_data1(rd_data1), .rd_data2(rd_data2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: turn = whose tie it is (0 ALU, 1 MEM).
  bit        model_on = 1'b0;
  int        turn = 0;
  bit [7:0]  m_busy = 8'h00;
  bit        m_we = 1'b0;
  bit [2:0]  m_wreg = 3'd0;
  bit [15:0] m_wdata = 16'h0;

  // Who wins this cycle: 0 ALU, 1 MEM, 2 nobody.
  function automatic int winner(input bit r, input bit a, input bit m, input int t);
    if (r) return 2;
    if (a && m) return t;
    if (a) return 0;
    if (m) return 1;
    return 2;
  endfunction

  always @(posedge clk) begin
    int w;
    w = winner(rst, alu_valid, mem_valid, turn);
    if (rst) begin
      model_on = 1'b1;
      turn = 0; m_busy = 8'h00; m_we = 1'b0; m_wreg = 3'd0; m_wdata = 16'h0;
    end else begin
      m_we = (w != 2);
      if (w == 0) begin m_wreg = alu_reg; m_wdata = alu_data; m_busy[alu_reg] = 1'b0; end
      if (w == 1) begin m_wreg = mem_reg; m_wdata = mem_data; m_busy[mem_reg] = 1'b0; end
      if (alu_valid && mem_valid) turn = 1 - w;
      if (issue_valid) m_busy[issue_reg] = 1'b1;
    end
  end

  always @(negedge clk) begin
    int w;
    if (model_on) begin
      w = winner(rst, alu_valid, mem_valid, turn);
      chk("alu_ready", {31'd0, alu_ready}, {31'd0, w == 0});
      chk("mem_ready", {31'd0, mem_ready}, {31'd0, w == 1});
      chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
      chk("rf_wreg", {29'd0, rf_wreg}, {29'd0, m_wreg});
      chk("rf_wdata", {16'd0, rf_wdata}, {16'd0, m_wdata});
      chk("busy", {24'd0, busy}, {24'd0, m_busy});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  int seq[4];
  bit a_acc, m_acc;

  initial begin
    // Reset: readies stay low even with requests pending.
    rst = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1;
    cyc(); cyc();
    #1;
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_busy", {24'd0, busy}, 32'h00);
    do_reset();
    cyc();

    // Single ALU writeback.
    alu_valid = 1'b1; alu_reg = 3'd3; alu_data = 16'h0FA3;
    #1 chk("single_alu_ready", {31'd0, alu_ready}, 32'd1);
    cyc(); idle();
    chk("single_we", {31'd0, rf_we}, 32'd1);
    chk("single_wreg", {29'd0, rf_wreg}, 32'd3);
    chk("single_wdata", {16'd0, rf_wdata}, 32'h0FA3);
    cyc();
    chk("idle_we", {31'd0, rf_we}, 32'd0);
    chk("idle_hold_wdata", {16'd0, rf_wdata}, 32'h0FA3);

    // Contested round-robin after reset.
    do_reset();
    alu_valid = 1'b1; alu_reg = 3'd1; alu_data = 16'h0001;
    mem_valid = 1'b1; mem_reg = 3'd2; mem_data = 16'h0002;
    for (int i = 0; i < 4; i++) begin
      #1 seq[i] = alu_ready ? 0 : (mem_ready ? 1 : 2);
      cyc();
    end
    idle();
    chk("rr_grant0", seq[0], 32'd0);
    chk("rr_grant1", seq[1], 32'd1);
    chk("rr_grant2", seq[2], 32'd0);
    chk("rr_grant3", seq[3], 32'd1);
    chk("rr_last_wdata", {16'd0, rf_wdata}, 32'h0002);

    // Scoreboard: issue reg5 at N, mem write to reg5 at N+3.
    issue_valid = 1'b1; issue_reg = 3'd5;
    cyc(); idle();
    chk("busy5_n1", {31'd0, busy[5]}, 32'd1);
    cyc();
    chk("busy5_n2", {31'd0, busy[5]}, 32'd1);
    cyc();
    chk("busy5_n3", {31'd0, busy[5]}, 32'd1);
    mem_valid = 1'b1; mem_reg = 3'd5; mem_data = 16'h5555;
    #1 chk("busy5_mem_ready", {31'd0, mem_ready}, 32'd1);
    cyc(); idle();
    chk("busy5_n4", {31'd0, busy[5]}, 32'd0);

    // Set and clear of reg6 in the same cycle: set wins.
    issue_valid = 1'b1; issue_reg = 3'd6;
    alu_valid = 1'b1; alu_reg = 3'd6; alu_data = 16'h6666;
    cyc(); idle();
    chk("busy6_set_wins", {31'd0, busy[6]}, 32'd1);

    // Reset during a would-be transfer, pointer left on MEM beforehand.
    alu_valid = 1'b1; mem_valid = 1'b1; alu_reg = 3'd7; mem_reg = 3'd7;
    alu_data = 16'hAAAA; mem_data = 16'hBBBB;
    cyc();
    rst = 1'b1; issue_valid = 1'b1; issue_reg = 3'd2;
    #1 chk("rst_cycle_no_ready", {30'd0, alu_ready, mem_ready}, 32'd0);
    cyc();
    rst = 1'b0; idle();
    chk("rst_discard_we", {31'd0, rf_we}, 32'd0);
    chk("rst_busy_clear", {24'd0, busy}, 32'h00);
    alu_valid = 1'b1; mem_valid = 1'b1;
    #1 chk("rst_ptr_alu", {30'd0, alu_ready, mem_ready}, 32'd2);
    cyc(); idle();

`ifdef WB_BYPASS_EN
    alu_valid = 1'b1; alu_reg = 3'd4; alu_data = 16'hBEEF;
    cyc(); idle();
    rd_reg1 = 3'd4; rf_r1 = 16'h0000; rd_reg2 = 3'd7; rf_r2 = 16'h1234;
    #1;
    chk("bypass_rd1", {16'd0, rd_data1}, 32'hBEEF);
    chk("bypass_rd2", {16'd0, rd_data2}, 32'h1234);
    cyc();
`endif

    // Mixed traffic, requesters hold until accepted; model checks each cycle.
    for (int i = 0; i < 60; i++) begin
      if (!(alu_valid && !a_acc)) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_reg = 3'($urandom_range(0, 7)); alu_data = 16'($urandom);
      end
      if (!(mem_valid && !m_acc)) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_reg = 3'($urandom_range(0, 7)); mem_data = 16'($urandom);
      end
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_reg = 3'($urandom_range(0, 7));
      #1 a_acc = alu_ready; m_acc = mem_ready;
      cyc();
    end
    idle();
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected end before %0t", $time);
    $fatal(1);
  end

endmodule
